// File: rtl/func_trace_stack.sv
// Shadow return-address stack that classifies retired calls/returns and
// queues one trace record per event into a small ready/valid FIFO.
module func_trace_stack #(
    parameter int STACK_DEPTH = 16,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         evt_valid,
    input  logic                         is_call,
    input  logic                         is_ret,
    input  logic [31:0]                  pc,
    input  logic [31:0]                  nextpc,
    output logic [$clog2(STACK_DEPTH):0] depth,
    output logic                         ret_mismatch,
    output logic                         overflow,
    output logic                         underflow,
    output logic                         rec_valid,
    input  logic                         rec_ready,
    output logic [1:0]                   rec_kind,
    output logic [31:0]                  rec_pc,
    output logic [31:0]                  rec_target,
    output logic [$clog2(STACK_DEPTH):0] rec_depth,
    output logic [7:0]                   drop_cnt
);

    localparam int SAW = $clog2(STACK_DEPTH);
    localparam int DW  = SAW + 1;
    localparam int FAW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        KIND_CALL     = 2'b00,
        KIND_RET_OK   = 2'b01,
        KIND_RET_BAD  = 2'b10,
        KIND_RET_CALL = 2'b11
    } kind_e;

    typedef struct packed {
        kind_e         kind;
        logic [31:0]   pc;
        logic [31:0]   target;
        logic [DW-1:0] depth;
    } rec_t;

    // Return-address stack
    logic [31:0]    stack_q [STACK_DEPTH];
    logic [DW-1:0]  depth_q, depth_d;
    logic           mis_q, mis_d;
    logic           ovf_q, ovf_d;
    logic           unf_q, unf_d;
    logic           ev, stack_full, stack_empty, ret_match, stack_we;
    logic [SAW-1:0] top_idx, stack_widx;
    logic [31:0]    ret_addr;
    kind_e          kind;

    // Record FIFO
    rec_t           fifo_q [FIFO_DEPTH];
    rec_t           new_rec;
    logic [FAW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FAW:0]   count_q, count_d;
    logic [7:0]     drop_q, drop_d;
    logic           fifo_full, deq, enq, drop;

    assign ev          = evt_valid & (is_call | is_ret);
    assign stack_full  = (depth_q == DW'(STACK_DEPTH));
    assign stack_empty = (depth_q == '0);
    assign top_idx     = SAW'(depth_q - 1'b1);
    assign ret_match   = !stack_empty && (nextpc == stack_q[top_idx]);
    assign ret_addr    = pc + 32'd4;

    always_comb begin
        // NOTE: every comb output gets a default first, so no path can infer a latch.
        depth_d    = depth_q;
        mis_d      = 1'b0;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        stack_we   = 1'b0;
        stack_widx = depth_q[SAW-1:0];
        kind       = KIND_CALL;
        if (ev) begin
            if (is_ret) begin
                mis_d = !ret_match;
                unf_d = unf_q | stack_empty;
                if (is_call) begin
                    // Tail call: pop-then-push collapses to overwriting the top.
                    kind     = KIND_RET_CALL;
                    stack_we = 1'b1;
                    if (stack_empty) begin
                        depth_d    = DW'(1);
                        stack_widx = '0;
                    end else begin
                        stack_widx = top_idx;
                    end
                end else begin
                    kind = ret_match ? KIND_RET_OK : KIND_RET_BAD;
                    if (!stack_empty) depth_d = depth_q - 1'b1;
                end
            end else if (stack_full) begin
                ovf_d = 1'b1;
            end else begin
                stack_we = 1'b1;
                depth_d  = depth_q + 1'b1;
            end
        end
    end

    always_comb begin
        fifo_full = (count_q == (FAW+1)'(FIFO_DEPTH));
        deq       = (count_q != '0) && rec_ready;
        enq       = ev && (!fifo_full || deq);
        drop      = ev && fifo_full && !deq;
        new_rec   = '{kind: kind, pc: pc, target: nextpc, depth: depth_d};
        wr_ptr_d  = enq ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = deq ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d   = count_q;
        if (enq && !deq)      count_d = count_q + 1'b1;
        else if (!enq && deq) count_d = count_q - 1'b1;
        drop_d    = (drop && drop_q != 8'hFF) ? drop_q + 1'b1 : drop_q;
    end

    // NOTE: storage arrays carry no reset; occupancy counters alone decide what is valid.
    always_ff @(posedge clock) begin
        if (stack_we) stack_q[stack_widx] <= ret_addr;
        if (enq)      fifo_q[wr_ptr_q]    <= new_rec;
    end

    // NOTE: state registers use non-blocking assignments only.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            depth_q  <= '0;
            mis_q    <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
        end else begin
            depth_q  <= depth_d;
            mis_q    <= mis_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
        end
    end

    assign depth        = depth_q;
    assign ret_mismatch = mis_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;
    assign drop_cnt     = drop_q;
    assign rec_valid    = (count_q != '0);
    assign rec_kind     = fifo_q[rd_ptr_q].kind;
    assign rec_pc       = fifo_q[rd_ptr_q].pc;
    assign rec_target   = fifo_q[rd_ptr_q].target;
    assign rec_depth    = fifo_q[rd_ptr_q].depth;

endmodule

// File: tb/tb_func_trace_stack.sv
// Directed bench for func_trace_stack: a vector table for single-event behaviour
// plus hand sequences for overflow, FIFO backpressure and asynchronous reset.
module tb_func_trace_stack;

    logic        clock = 1'b0;
    logic        reset;
    logic        evt_valid, is_call, is_ret, rec_ready;
    logic [31:0] pc, nextpc;
    logic [4:0]  depth, rec_depth;
    logic        ret_mismatch, overflow, underflow, rec_valid;
    logic [1:0]  rec_kind;
    logic [31:0] rec_pc, rec_target;
    logic [7:0]  drop_cnt;

    int checks   = 0;
    int failures = 0;

    func_trace_stack #(.STACK_DEPTH(16), .FIFO_DEPTH(8)) dut (
        .clock(clock), .reset(reset), .evt_valid(evt_valid), .is_call(is_call),
        .is_ret(is_ret), .pc(pc), .nextpc(nextpc), .depth(depth),
        .ret_mismatch(ret_mismatch), .overflow(overflow), .underflow(underflow),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_kind(rec_kind),
        .rec_pc(rec_pc), .rec_target(rec_target), .rec_depth(rec_depth),
        .drop_cnt(drop_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        ev, call, ret;
        logic [31:0] pc, npc;
        logic [4:0]  e_depth;
        logic        e_mis, e_unf, e_rv;
        logic [1:0]  e_kind;
        logic [4:0]  e_rdepth;
    } vec_t;

    vec_t tbl [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic c, input logic r,
                         input logic [31:0] p, input logic [31:0] n);
        evt_valid = v; is_call = c; is_ret = r; pc = p; nextpc = n;
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step(input logic v, input logic c, input logic r,
                        input logic [31:0] p, input logic [31:0] n);
        drive(v, c, r, p, n);
        @(negedge clock);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{0, 0, 0, 32'h0,        32'h0,        5'd0, 0, 0, 0, 2'b00, 5'd0};
        tbl[1]  = '{1, 1, 0, 32'h80000010, 32'h80001000, 5'd1, 0, 0, 1, 2'b00, 5'd1};
        tbl[2]  = '{1, 0, 1, 32'h80001004, 32'h80000014, 5'd0, 0, 0, 1, 2'b01, 5'd0};
        tbl[3]  = '{1, 0, 0, 32'h50,       32'h60,       5'd0, 0, 0, 0, 2'b00, 5'd0};
        tbl[4]  = '{1, 1, 0, 32'h100,      32'h300,      5'd1, 0, 0, 1, 2'b00, 5'd1};
        tbl[5]  = '{1, 0, 1, 32'h304,      32'h200,      5'd0, 1, 0, 1, 2'b10, 5'd0};
        tbl[6]  = '{0, 0, 0, 32'h0,        32'h0,        5'd0, 0, 0, 0, 2'b00, 5'd0};
        tbl[7]  = '{1, 0, 1, 32'h500,      32'h600,      5'd0, 1, 1, 1, 2'b10, 5'd0};
        tbl[8]  = '{1, 1, 0, 32'h40,       32'h1000,     5'd1, 0, 1, 1, 2'b00, 5'd1};
        tbl[9]  = '{1, 0, 1, 32'h1004,     32'h44,       5'd0, 0, 1, 1, 2'b01, 5'd0};
        tbl[10] = '{1, 1, 0, 32'h10,       32'h800,      5'd1, 0, 1, 1, 2'b00, 5'd1};
        tbl[11] = '{1, 1, 1, 32'h900,      32'h14,       5'd1, 0, 1, 1, 2'b11, 5'd1};
        tbl[12] = '{1, 1, 1, 32'hA00,      32'h999,      5'd1, 1, 1, 1, 2'b11, 5'd1};
        tbl[13] = '{1, 0, 1, 32'hB00,      32'h777,      5'd0, 1, 1, 1, 2'b10, 5'd0};
        tbl[14] = '{1, 0, 1, 32'hC00,      32'h0,        5'd0, 1, 1, 1, 2'b10, 5'd0};
        tbl[15] = '{1, 1, 1, 32'h20,       32'h50,       5'd1, 1, 1, 1, 2'b11, 5'd1};
        tbl[16] = '{1, 0, 1, 32'hD00,      32'h24,       5'd0, 0, 1, 1, 2'b01, 5'd0};
        tbl[17] = '{0, 1, 0, 32'hE00,      32'h0,        5'd0, 0, 1, 0, 2'b00, 5'd0};

        reset = 1'b1;
        rec_ready = 1'b1;
        drive(0, 0, 0, 0, 0);
        @(negedge clock);
        @(negedge clock);
        check("rst_depth", depth, 0);
        check("rst_rec_valid", rec_valid, 0);
        check("rst_flags", {ret_mismatch, overflow, underflow}, 0);
        check("rst_drop", drop_cnt, 0);
        reset = 1'b0;

        // Single-event table; consumer always ready so the head is the last event.
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].ev, tbl[i].call, tbl[i].ret, tbl[i].pc, tbl[i].npc);
            check($sformatf("v%0d_depth", i), depth, tbl[i].e_depth);
            check($sformatf("v%0d_mis", i), ret_mismatch, tbl[i].e_mis);
            check($sformatf("v%0d_unf", i), underflow, tbl[i].e_unf);
            check($sformatf("v%0d_ovf", i), overflow, 0);
            check($sformatf("v%0d_rv", i), rec_valid, tbl[i].e_rv);
            if (tbl[i].e_rv) begin
                check($sformatf("v%0d_kind", i), rec_kind, tbl[i].e_kind);
                check($sformatf("v%0d_rpc", i), rec_pc, tbl[i].pc);
                check($sformatf("v%0d_rtgt", i), rec_target, tbl[i].npc);
                check($sformatf("v%0d_rdepth", i), rec_depth, tbl[i].e_rdepth);
            end
        end

        // Overflow: 17 calls into a 16-deep stack, then 16 matching returns.
        do_reset();
        check("a_unf_cleared", underflow, 0);
        for (int i = 0; i < 17; i++) begin
            step(1, 1, 0, 32'h1000 + 32'(i * 16), 32'h7000);
            check($sformatf("a_call%0d_depth", i), depth, (i < 16) ? i + 1 : 16);
            check($sformatf("a_call%0d_ovf", i), overflow, (i == 16) ? 1 : 0);
        end
        check("a_call16_kind", rec_kind, 2'b00);
        check("a_call16_rdepth", rec_depth, 16);
        for (int i = 15; i >= 0; i--) begin
            step(1, 0, 1, 32'h7100, 32'h1004 + 32'(i * 16));
            check($sformatf("a_ret%0d_kind", i), rec_kind, 2'b01);
            check($sformatf("a_ret%0d_mis", i), ret_mismatch, 0);
            check($sformatf("a_ret%0d_depth", i), depth, i);
        end
        check("a_ovf_sticky", overflow, 1);

        // Backpressure: 10 events into an 8-entry FIFO, then drain in order.
        do_reset();
        check("b_ovf_cleared", overflow, 0);
        rec_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, 0, 32'h2000 + 32'(i * 16), 32'h3000 + 32'(i));
            if (i == 0) begin
                #1 check("b_no_bypass", rec_valid, 0);
            end
            @(negedge clock);
        end
        step(0, 0, 0, 0, 0);
        check("b_drop", drop_cnt, 2);
        check("b_depth", depth, 10);
        check("b_rv", rec_valid, 1);
        check("b_head", rec_pc, 32'h2000);
        @(negedge clock);
        check("b_hold_pc", rec_pc, 32'h2000);
        check("b_hold_tgt", rec_target, 32'h3000);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("b_drain%0d_pc", i), rec_pc, 32'h2000 + 32'(i * 16));
            check($sformatf("b_drain%0d_rdepth", i), rec_depth, i + 1);
            rec_ready = 1'b1;
            @(negedge clock);
            rec_ready = 1'b0;
        end
        check("b_empty", rec_valid, 0);

        // Full FIFO with a same-edge dequeue accepts the new record.
        for (int i = 0; i < 8; i++) step(1, 1, 1, 32'h4000 + 32'(i * 16), 32'h0);
        check("b_refill_drop", drop_cnt, 2);
        check("b_refill_depth", depth, 10);
        rec_ready = 1'b1;
        step(1, 1, 0, 32'h5000, 32'h0);
        rec_ready = 1'b0;
        drive(0, 0, 0, 0, 0);
        check("b_fulldeq_drop", drop_cnt, 2);
        check("b_fulldeq_head", rec_pc, 32'h4010);

        // Asynchronous reset mid-stream at depth 3 with 4 records queued.
        do_reset();
        step(1, 1, 0, 32'h6000, 32'h0);
        step(1, 1, 0, 32'h6010, 32'h0);
        step(1, 1, 0, 32'h6020, 32'h0);
        step(1, 1, 1, 32'h6100, 32'h9999);
        drive(0, 0, 0, 0, 0);
        check("c_pre_depth", depth, 3);
        check("c_pre_mis", ret_mismatch, 1);
        check("c_pre_rv", rec_valid, 1);
        #2 reset = 1'b1;
        #1;
        check("c_async_depth", depth, 0);
        check("c_async_rv", rec_valid, 0);
        check("c_async_mis", ret_mismatch, 0);
        check("c_async_flags", {overflow, underflow}, 0);
        check("c_async_drop", drop_cnt, 0);
        drive(1, 1, 0, 32'h7000, 32'h0);
        @(negedge clock);
        check("c_ignored_in_reset", depth, 0);
        reset = 1'b0;
        step(1, 1, 0, 32'h7770, 32'h0);
        drive(0, 0, 0, 0, 0);
        check("c_first_depth", depth, 1);
        check("c_first_rv", rec_valid, 1);
        check("c_first_pc", rec_pc, 32'h7770);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/func_trace_stack.md
FUNC_TRACE_STACK -- requirements
Module: func_trace_stack

Interface
REQ-001 SHALL have parameter STACK_DEPTH, default 16, shadow return-address stack entries (power of 2, >= 2).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, trace-record FIFO entries (power of 2, >= 2).
REQ-003 SHALL have port clock  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port evt_valid  in  1  one retired control-transfer event this cycle.
REQ-006 SHALL have port is_call  in  1  event is a call (jal/jalr writing ra).
REQ-007 SHALL have port is_ret  in  1  event is a return (jalr rs1=ra, rd=x0).
REQ-008 SHALL have port pc  in  32  address of the event instruction.
REQ-009 SHALL have port nextpc  in  32  target address of the event.
REQ-010 SHALL have port depth  out  log2(STACK_DEPTH)+1  current stack occupancy.
REQ-011 SHALL have port ret_mismatch  out  1  one-cycle pulse: return target differed from the predicted address.
REQ-012 SHALL have port overflow  out  1  sticky flag: a push was attempted while the stack was full.
REQ-013 SHALL have port underflow  out  1  sticky flag: a pop was attempted while the stack was empty.
REQ-014 SHALL have port rec_valid  out  1  trace record available.
REQ-015 SHALL have port rec_ready  in  1  consumer accepts the record.
REQ-016 SHALL have port rec_kind  out  2  record kind: 00 call, 01 ret-ok, 10 ret-mismatch, 11 ret+call.
REQ-017 SHALL have port rec_pc  out  32  pc of the recorded event.
REQ-018 SHALL have port rec_target  out  32  nextpc of the recorded event.
REQ-019 SHALL have port rec_depth  out  log2(STACK_DEPTH)+1  depth after the recorded event was applied.
REQ-020 SHALL have port drop_cnt  out  8  saturating count of records lost to a full FIFO.

Function
REQ-021 An event SHALL be processed only when evt_valid=1 and (is_call | is_ret)=1; all other inputs SHALL be ignored.
REQ-022 Call only (is_call=1, is_ret=0), stack not full: SHALL push pc+4 (mod 2^32) and increment depth; rec_kind=00.
REQ-023 Call only, stack full: SHALL leave the stack and depth unchanged, set overflow, and still enqueue a kind-00 record.
REQ-024 Return only, depth>0: SHALL pop the stack and decrement depth; nextpc==top gives kind 01, otherwise kind 10 plus ret_mismatch.
REQ-025 Return only, depth==0: SHALL set underflow, leave depth at 0, pulse ret_mismatch, and record kind 10.
REQ-026 is_call and is_ret both set: SHALL pop and compare as in REQ-024/025, then push pc+4, with rec_kind=11.
REQ-027 For REQ-026 with depth>0, the top entry SHALL be replaced and depth SHALL be unchanged; with depth==0, depth SHALL become 1 and underflow SHALL be set.
REQ-028 A kind-11 record with a mismatch SHALL still pulse ret_mismatch.
REQ-029 depth, ret_mismatch, overflow and underflow SHALL be registered and SHALL reflect an event on the cycle after it is sampled.
REQ-030 ret_mismatch SHALL be high for exactly one cycle per mismatching event, and SHALL be high on consecutive cycles for back-to-back mismatches.
REQ-031 The record FIFO SHALL enqueue on the event's sampling edge; rec_valid SHALL rise no earlier than the following cycle (1-cycle latency).
REQ-032 The FIFO head SHALL dequeue on a rising edge where rec_valid=1 and rec_ready=1.
REQ-033 rec_* outputs SHALL hold stable while rec_valid=1 and rec_ready=0.
REQ-034 FIFO full with no dequeue that same edge: the new record SHALL be discarded and drop_cnt SHALL increment, saturating at 255.
REQ-035 FIFO full with a simultaneous dequeue: the enqueue SHALL succeed with no drop.
REQ-036 FIFO empty with a simultaneous enqueue: no bypass; the record SHALL appear the next cycle.
REQ-037 Pointers SHALL wrap modulo depth, and occupancy SHALL distinguish full from empty.
REQ-038 Stack entry storage SHALL need no reset; only valid entries below depth SHALL ever be compared.

Reset
REQ-039 Asserting reset SHALL, asynchronously and at any time including mid-operation, force: depth=0, ret_mismatch=0, overflow=0, underflow=0, rec_valid=0, drop_cnt=0, FIFO empty.
REQ-040 While reset is high, events SHALL be ignored.
REQ-041 On the first rising edge after reset deasserts, an event SHALL be processed normally.
REQ-042 Sticky flags SHALL clear only on reset.

Verification
REQ-043 Bench SHALL cover: call pc=0x80000010 then return nextpc=0x80000014 -> depth 1 then 0; records 00 then 01; no ret_mismatch.
REQ-044 Bench SHALL cover: call pc=0x100, then return nextpc=0x200 -> ret_mismatch 1 cycle; kind 10; depth 0.
REQ-045 Bench SHALL cover: 17 calls with STACK_DEPTH=16 -> depth holds 16; overflow=1 after the 17th; then 16 returns with matching targets all kind 01.
REQ-046 Bench SHALL cover: return at depth 0 -> underflow=1, ret_mismatch pulse, depth 0; then a call pc=0x40, ret nextpc=0x44 -> kind 01.
REQ-047 Bench SHALL cover: rec_ready=0 and 10 events with FIFO_DEPTH=8 -> 8 records held, drop_cnt=2; drain all 8 in original order.
REQ-048 Bench SHALL cover: reset asserted mid-stream at depth 3 with 4 records queued -> all outputs at reset values immediately, without waiting for a clock edge.
